// File: rtl/ptp_bridge_avmm_addr_router_if.sv
// ---------------------------------------------------------------------------
// ptp_bridge_avmm_addr_router_if
//
// Bundles the host-side Avalon-MM slave port and the fan-out channel ports of
// the PTP bridge address router.
//
// Host side:
//   avmm_address/read/write/writedata/byteenable   host -> router
//   avmm_waitrequest/readdata/readdatavalid/response router -> host
// Channel side:
//   ch_address (NUM_CH lanes), ch_read, ch_write      router -> channels
//   ch_writedata, ch_byteenable (shared by all lanes) router -> channels
//   ch_readdata (NUM_CH lanes), ch_readdatavalid      channels -> router
//
// Modports:
//   slave  - the router itself
//   master - the environment (host plus channel endpoints)
// ---------------------------------------------------------------------------
interface ptp_bridge_avmm_addr_router_if #(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32
);

    // Host port
    logic [ADDR_WIDTH-1:0]          avmm_address;
    logic                           avmm_read;
    logic                           avmm_write;
    logic [DATA_WIDTH-1:0]          avmm_writedata;
    logic [DATA_WIDTH/8-1:0]        avmm_byteenable;
    logic                           avmm_waitrequest;
    logic [DATA_WIDTH-1:0]          avmm_readdata;
    logic                           avmm_readdatavalid;
    logic [1:0]                     avmm_response;

    // Channel ports
    logic [NUM_CH*ADDR_WIDTH-1:0]   ch_address;
    logic [NUM_CH-1:0]              ch_read;
    logic [NUM_CH-1:0]              ch_write;
    logic [DATA_WIDTH-1:0]          ch_writedata;
    logic [DATA_WIDTH/8-1:0]        ch_byteenable;
    logic [NUM_CH*DATA_WIDTH-1:0]   ch_readdata;
    logic [NUM_CH-1:0]              ch_readdatavalid;

    modport slave (
        input  avmm_address,
        input  avmm_read,
        input  avmm_write,
        input  avmm_writedata,
        input  avmm_byteenable,
        output avmm_waitrequest,
        output avmm_readdata,
        output avmm_readdatavalid,
        output avmm_response,
        output ch_address,
        output ch_read,
        output ch_write,
        output ch_writedata,
        output ch_byteenable,
        input  ch_readdata,
        input  ch_readdatavalid
    );

    modport master (
        output avmm_address,
        output avmm_read,
        output avmm_write,
        output avmm_writedata,
        output avmm_byteenable,
        input  avmm_waitrequest,
        input  avmm_readdata,
        input  avmm_readdatavalid,
        input  avmm_response,
        input  ch_address,
        input  ch_read,
        input  ch_write,
        input  ch_writedata,
        input  ch_byteenable,
        output ch_readdata,
        output ch_readdatavalid
    );

endinterface

// File: rtl/ptp_bridge_avmm_addr_router.sv
// ---------------------------------------------------------------------------
// ptp_bridge_avmm_addr_router
//
// Routes single Avalon-MM host accesses to one of NUM_CH downstream channel
// windows. One command is in flight at a time; the host is held off with
// waitrequest whenever the router is not idle.
//
//   IDLE    accept a command (read wins if read and write are both set)
//   ISSUE   one-cycle read/write pulse on the selected channel
//   WAIT_RD wait for the selected channel's readdatavalid, bounded by
//           TIMEOUT_CYCLES
//   RESP    one-cycle readdatavalid to the host
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   bus             host + channel signals (slave modport of the interface;
//                   its NUM_CH/ADDR_WIDTH/DATA_WIDTH must match this module)
//   unmapped_cnt    saturating count of accesses that hit no window
//   timeout_cnt     saturating count of read timeouts
//
// Responses: 00 OKAY, 10 SLVERR (timeout), 11 DECODEERROR (unmapped read).
// ---------------------------------------------------------------------------
module ptp_bridge_avmm_addr_router #(
    parameter int unsigned                   NUM_CH         = 2,
    parameter int unsigned                   ADDR_WIDTH     = 16,
    parameter int unsigned                   DATA_WIDTH     = 32,
    parameter logic [NUM_CH*ADDR_WIDTH-1:0]  CH_BASE        = {16'h8238, 16'h8218},
    parameter logic [NUM_CH*ADDR_WIDTH-1:0]  CH_SPAN        = {16'h0020, 16'h0020},
    parameter int unsigned                   TIMEOUT_CYCLES = 64,
    parameter logic [DATA_WIDTH-1:0]         ERR_RDATA      = 32'hDEADBEEF
) (
    input  logic                                clk,
    input  logic                                rst_n,
    ptp_bridge_avmm_addr_router_if.slave        bus,
    output logic [15:0]                         unmapped_cnt,
    output logic [15:0]                         timeout_cnt
);

    localparam int unsigned BeWidth  = DATA_WIDTH / 8;
    localparam int unsigned SelWidth = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned TmoWidth = $clog2(TIMEOUT_CYCLES + 1);
    // Counter value seen on the last allowed WAIT_RD cycle.
    localparam logic [TmoWidth-1:0] TmoLast = TmoWidth'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [1:0] RespDecErr = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitRd,
        StResp
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [BeWidth-1:0]     be_q, be_d;
    logic                   is_read_q, is_read_d;
    logic                   hit_q, hit_d;
    logic [SelWidth-1:0]    sel_q, sel_d;
    logic [TmoWidth-1:0]    tmo_q, tmo_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic [1:0]             resp_q, resp_d;
    logic [15:0]            unm_cnt_q, unm_cnt_d;
    logic [15:0]            tmo_cnt_q, tmo_cnt_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // -----------------------------------------------------------------------
    // Address decode on the live host address. Bounds are widened by one bit
    // so that base + span never wraps; an empty span matches nothing.
    // -----------------------------------------------------------------------
    logic [ADDR_WIDTH:0]    addr_ext;
    logic [NUM_CH-1:0]      win_hit;
    logic                   dec_hit;
    logic [SelWidth-1:0]    dec_sel;

    assign addr_ext = {1'b0, bus.avmm_address};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_win
        localparam logic [ADDR_WIDTH:0] Lo = {1'b0, CH_BASE[g*ADDR_WIDTH +: ADDR_WIDTH]};
        localparam logic [ADDR_WIDTH:0] Hi = Lo + {1'b0, CH_SPAN[g*ADDR_WIDTH +: ADDR_WIDTH]};
        assign win_hit[g] = (addr_ext >= Lo) && (addr_ext < Hi);
    end

    // Scan from the top down so the lowest matching index is the one kept.
    always_comb begin
        dec_hit = 1'b0;
        dec_sel = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (win_hit[i]) begin
                dec_hit = 1'b1;
                dec_sel = SelWidth'(i);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Selected-channel read return; valids from other channels are masked.
    // -----------------------------------------------------------------------
    logic                   sel_valid;
    logic [DATA_WIDTH-1:0]  sel_rdata;

    always_comb begin
        sel_valid = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (hit_q && (sel_q == SelWidth'(i))) begin
                sel_valid = bus.ch_readdatavalid[i];
                sel_rdata = bus.ch_readdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Channel command outputs: only the selected lane is driven, only in ISSUE.
    // -----------------------------------------------------------------------
    logic                           issue_hit;
    logic [NUM_CH-1:0]              ch_read_vec;
    logic [NUM_CH-1:0]              ch_write_vec;
    logic [NUM_CH*ADDR_WIDTH-1:0]   ch_addr_vec;

    assign issue_hit = (state_q == StIssue) && hit_q;

    always_comb begin
        ch_read_vec  = '0;
        ch_write_vec = '0;
        ch_addr_vec  = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (issue_hit && (sel_q == SelWidth'(i))) begin
                ch_read_vec[i]  = is_read_q;
                ch_write_vec[i] = !is_read_q;
                ch_addr_vec[i*ADDR_WIDTH +: ADDR_WIDTH] =
                    addr_q - CH_BASE[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    assign bus.ch_read       = ch_read_vec;
    assign bus.ch_write      = ch_write_vec;
    assign bus.ch_address    = ch_addr_vec;
    assign bus.ch_writedata  = wdata_q;
    assign bus.ch_byteenable = be_q;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        is_read_d = is_read_q;
        hit_d     = hit_q;
        sel_d     = sel_q;
        tmo_d     = tmo_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        unm_cnt_d = unm_cnt_q;
        tmo_cnt_d = tmo_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (bus.avmm_read || bus.avmm_write) begin
                    addr_d    = bus.avmm_address;
                    wdata_d   = bus.avmm_writedata;
                    be_d      = bus.avmm_byteenable;
                    is_read_d = bus.avmm_read;
                    hit_d     = dec_hit;
                    sel_d     = dec_sel;
                    state_d   = StIssue;
                end
            end

            StIssue: begin
                tmo_d = '0;
                if (!hit_q) begin
                    unm_cnt_d = sat_inc(unm_cnt_q);
                    if (is_read_q) begin
                        rdata_d = ERR_RDATA;
                        resp_d  = RespDecErr;
                        state_d = StResp;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (!is_read_q) begin
                    state_d = StIdle;
                end else if (sel_valid) begin
                    // Channel answered in the same cycle as the pulse.
                    rdata_d = sel_rdata;
                    resp_d  = RespOkay;
                    state_d = StResp;
                end else begin
                    state_d = StWaitRd;
                end
            end

            StWaitRd: begin
                // A valid on the terminal cycle still counts as a good read.
                if (sel_valid) begin
                    rdata_d = sel_rdata;
                    resp_d  = RespOkay;
                    state_d = StResp;
                end else if (tmo_q == TmoLast) begin
                    rdata_d   = ERR_RDATA;
                    resp_d    = RespSlvErr;
                    tmo_cnt_d = sat_inc(tmo_cnt_q);
                    state_d   = StResp;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            StResp: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            is_read_q <= 1'b0;
            hit_q     <= 1'b0;
            sel_q     <= '0;
            tmo_q     <= '0;
            rdata_q   <= '0;
            resp_q    <= RespOkay;
            unm_cnt_q <= '0;
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            is_read_q <= is_read_d;
            hit_q     <= hit_d;
            sel_q     <= sel_d;
            tmo_q     <= tmo_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            unm_cnt_q <= unm_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Host outputs; read data and response are zeroed outside RESP.
    // -----------------------------------------------------------------------
    logic in_resp;

    assign in_resp                = (state_q == StResp);
    assign bus.avmm_waitrequest   = (state_q != StIdle);
    assign bus.avmm_readdatavalid = in_resp;
    assign bus.avmm_readdata      = in_resp ? rdata_q : '0;
    assign bus.avmm_response      = in_resp ? resp_q : RespOkay;

    assign unmapped_cnt = unm_cnt_q;
    assign timeout_cnt  = tmo_cnt_q;

endmodule

// File: tb/tb_ptp_bridge_avmm_addr_router.sv
module tb_ptp_bridge_avmm_addr_router;

    localparam int NCH = 2;
    localparam int AW  = 16;
    localparam int DW  = 32;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] unmapped_cnt;
    logic [15:0] timeout_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ptp_bridge_avmm_addr_router_if #(
        .NUM_CH     (NCH),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) bus ();

    ptp_bridge_avmm_addr_router #(
        .NUM_CH         (NCH),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .CH_BASE        ({16'h8238, 16'h8218}),
        .CH_SPAN        ({16'h0020, 16'h0020}),
        .TIMEOUT_CYCLES (64),
        .ERR_RDATA      (32'hDEADBEEF)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .unmapped_cnt (unmapped_cnt),
        .timeout_cnt  (timeout_cnt)
    );

    // Vector record: stimulus plus expected behaviour.
    typedef struct {
        logic [15:0] addr;
        logic        rd;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          exp_ch;     // -1: unmapped
        logic [15:0] exp_off;
        int          vdelay;     // cycles after the pulse cycle for channel valid, -1 none
        logic [31:0] vdata;
        int          exp_lat;    // cycles from accept to host readdatavalid, 0 for writes
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        logic [15:0] exp_unm;
        logic [15:0] exp_tmo;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
        string       tag;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard: every host readdatavalid must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.avmm_readdatavalid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rdv actual=1 required=0");
            end else begin
                e = sb_q.pop_front();
                chk({e.tag, "_rdata"}, bus.avmm_readdata, e.rdata);
                chk({e.tag, "_resp"}, bus.avmm_response, e.resp);
            end
        end
    end

    task automatic drive_idle();
        bus.avmm_address    = '0;
        bus.avmm_read       = 1'b0;
        bus.avmm_write      = 1'b0;
        bus.avmm_writedata  = '0;
        bus.avmm_byteenable = '0;
        bus.ch_readdata     = '0;
        bus.ch_readdatavalid = '0;
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_wr"}, bus.avmm_waitrequest, 0);
        chk({nm, "_rdv"}, bus.avmm_readdatavalid, 0);
        chk({nm, "_resp"}, bus.avmm_response, 0);
        chk({nm, "_rdata"}, bus.avmm_readdata, 0);
        chk({nm, "_chrd"}, bus.ch_read, 0);
        chk({nm, "_chwr"}, bus.ch_write, 0);
        chk({nm, "_chaddr"}, bus.ch_address, 0);
        chk({nm, "_unm"}, unmapped_cnt, 0);
        chk({nm, "_tmo"}, timeout_cnt, 0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [NCH-1:0] exp_rd;
        logic [NCH-1:0] exp_wr;
        bit             done;
        string          nm;
        nm = $sformatf("v%0d", idx);
        exp_rd = '0;
        exp_wr = '0;
        if (v.exp_ch >= 0 && v.rd) exp_rd[v.exp_ch] = 1'b1;
        if (v.exp_ch >= 0 && !v.rd && v.wr) exp_wr[v.exp_ch] = 1'b1;

        @(negedge clk);
        chk({nm, "_idle_wr"}, bus.avmm_waitrequest, 0);
        bus.avmm_address    = v.addr;
        bus.avmm_read       = v.rd;
        bus.avmm_write      = v.wr;
        bus.avmm_writedata  = v.wdata;
        bus.avmm_byteenable = v.be;
        if (v.exp_lat != 0) sb_q.push_back('{rdata: v.exp_rdata, resp: v.exp_resp, tag: nm});

        done = 1'b0;
        for (int c = 1; c <= 100 && !done; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.avmm_read  = 1'b0;
                bus.avmm_write = 1'b0;
                chk({nm, "_issue_wr"}, bus.avmm_waitrequest, 1);
                chk({nm, "_ch_read"}, bus.ch_read, exp_rd);
                chk({nm, "_ch_write"}, bus.ch_write, exp_wr);
                if (v.exp_ch >= 0)
                    chk({nm, "_ch_addr"}, bus.ch_address[v.exp_ch*AW +: AW], v.exp_off);
                if (exp_wr != 0) begin
                    chk({nm, "_ch_wdata"}, bus.ch_writedata, v.wdata);
                    chk({nm, "_ch_be"}, bus.ch_byteenable, v.be);
                end
            end
            if (c == 2) chk({nm, "_pulse_end"}, {bus.ch_read, bus.ch_write}, 0);
            if (v.exp_lat == 0 && c == 2) begin
                chk({nm, "_wr_done"}, bus.avmm_waitrequest, 0);
                done = 1'b1;
            end else if (bus.avmm_readdatavalid) begin
                chk({nm, "_lat"}, c, v.exp_lat);
                done = 1'b1;
            end
            bus.ch_readdatavalid = '0;
            bus.ch_readdata      = {NCH{~v.vdata}};
            if (v.exp_ch >= 0) begin
                bus.ch_readdata[v.exp_ch*DW +: DW] = v.vdata;
                if (!done && v.vdelay == c - 1) bus.ch_readdatavalid[v.exp_ch] = 1'b1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_no_completion actual=none required=done", nm);
        end
        bus.ch_readdatavalid = '0;
        chk({nm, "_unm_cnt"}, unmapped_cnt, v.exp_unm);
        chk({nm, "_tmo_cnt"}, timeout_cnt, v.exp_tmo);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tail;
        bit   done;

        // addr rd wr wdata be ch off vdelay vdata lat resp rdata unm tmo
        vecs[0]  = '{16'h821C, 1'b0, 1'b1, 32'h12345678, 4'hF, 0, 16'h04, -1, 32'h0,
                     0, 2'b00, 32'h0, 16'd0, 16'd0};
        vecs[1]  = '{16'h8240, 1'b1, 1'b0, 32'h0, 4'hF, 1, 16'h08, 2, 32'hA5A5A5A5,
                     4, 2'b00, 32'hA5A5A5A5, 16'd0, 16'd0};
        vecs[2]  = '{16'h0100, 1'b1, 1'b0, 32'h0, 4'hF, -1, 16'h00, -1, 32'h0,
                     2, 2'b11, 32'hDEADBEEF, 16'd1, 16'd0};
        vecs[3]  = '{16'h8218, 1'b1, 1'b0, 32'h0, 4'hF, 0, 16'h00, 0, 32'h11112222,
                     2, 2'b00, 32'h11112222, 16'd1, 16'd0};
        vecs[4]  = '{16'h8257, 1'b1, 1'b1, 32'h55555555, 4'hF, 1, 16'h1F, 1, 32'h0BADF00D,
                     3, 2'b00, 32'h0BADF00D, 16'd1, 16'd0};
        vecs[5]  = '{16'h8258, 1'b0, 1'b1, 32'h01010101, 4'hF, -1, 16'h00, -1, 32'h0,
                     0, 2'b00, 32'h0, 16'd2, 16'd0};
        vecs[6]  = '{16'h8217, 1'b0, 1'b1, 32'h02020202, 4'hF, -1, 16'h00, -1, 32'h0,
                     0, 2'b00, 32'h0, 16'd3, 16'd0};
        vecs[7]  = '{16'h8237, 1'b0, 1'b1, 32'hCAFEBABE, 4'h3, 0, 16'h1F, -1, 32'h0,
                     0, 2'b00, 32'h0, 16'd3, 16'd0};
        vecs[8]  = '{16'h8218, 1'b1, 1'b0, 32'h0, 4'hF, 0, 16'h00, -1, 32'h0,
                     66, 2'b10, 32'hDEADBEEF, 16'd3, 16'd1};
        vecs[9]  = '{16'h8218, 1'b1, 1'b0, 32'h0, 4'hF, 0, 16'h00, 64, 32'h600DCAFE,
                     66, 2'b00, 32'h600DCAFE, 16'd3, 16'd1};
        vecs[10] = '{16'h8238, 1'b1, 1'b0, 32'h0, 4'hF, 1, 16'h00, 5, 32'h5A5A0000,
                     7, 2'b00, 32'h5A5A0000, 16'd3, 16'd1};
        vecs[11] = '{16'hFFFF, 1'b1, 1'b0, 32'h0, 4'hF, -1, 16'h00, -1, 32'h0,
                     2, 2'b11, 32'hDEADBEEF, 16'd4, 16'd1};

        drive_idle();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // Read channel 1 while channel 0 raises valid; only channel 1's valid counts.
        @(negedge clk);
        chk("ign_idle_wr", bus.avmm_waitrequest, 0);
        bus.avmm_address = 16'h8238;
        bus.avmm_read    = 1'b1;
        sb_q.push_back('{rdata: 32'h13572468, resp: 2'b00, tag: "ign"});
        done = 1'b0;
        for (int c = 1; c <= 20 && !done; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.avmm_read = 1'b0;
                chk("ign_ch_read", bus.ch_read, 2'b10);
            end
            if (bus.avmm_readdatavalid) begin
                chk("ign_lat", c, 5);
                done = 1'b1;
            end
            bus.ch_readdata      = {32'h13572468, 32'hFFFF0000};
            bus.ch_readdatavalid = (c == 1 || c == 2) ? 2'b01 : ((c == 4) ? 2'b10 : 2'b00);
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL ign_no_completion actual=none required=done");
        end
        bus.ch_readdatavalid = '0;

        // Reset while a read is pending in WAIT_RD; the late valid must be ignored.
        @(negedge clk);
        bus.avmm_address = 16'h8240;
        bus.avmm_read    = 1'b1;
        @(negedge clk);
        bus.avmm_read = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pending_wr", bus.avmm_waitrequest, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.ch_readdata      = {32'h77777777, 32'h66666666};
        bus.ch_readdatavalid = 2'b11;
        @(negedge clk);
        bus.ch_readdatavalid = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("rst_late_rdv%0d", c), bus.avmm_readdatavalid, 0);
            chk($sformatf("rst_late_wr%0d", c), bus.avmm_waitrequest, 0);
        end
        chk("rst_sb_empty", sb_q.size(), 0);

        // Normal operation after reset, counters restarted from zero.
        tail = vecs[11];
        tail.exp_unm = 16'd1;
        tail.exp_tmo = 16'd0;
        run_vec(12, tail);

        @(negedge clk);
        chk("end_sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ptp_bridge_avmm_addr_router.md
PTP_BRIDGE_AVMM_ADDR_ROUTER -- requirements
Module: ptp_bridge_avmm_addr_router

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, the number of downstream channels (1..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, the address width of the host and channel ports.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, the data width (multiple of 8).
REQ-004 SHALL have parameter CH_BASE, default {'h8238,'h8218}, packed NUM_CH x ADDR_WIDTH; the base address of each channel.
REQ-005 SHALL have parameter CH_SPAN, default {'h20,'h20}, packed NUM_CH x ADDR_WIDTH; the byte span of each channel window.
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 64, the read-wait limit (>=1).
REQ-007 SHALL have parameter ERR_RDATA, default 'hDEADBEEF, the readdata returned on any error.
REQ-008 SHALL have port clk, in, 1: the single clock.
REQ-009 SHALL have port rst_n, in, 1: reset, asynchronous and active-low.
REQ-010 SHALL have host ports avmm_address (in, ADDR_WIDTH), avmm_read (in, 1), avmm_write (in, 1), avmm_writedata (in, DATA_WIDTH) and avmm_byteenable (in, DATA_WIDTH/8).
REQ-011 SHALL have host ports avmm_waitrequest (out, 1), avmm_readdata (out, DATA_WIDTH), avmm_readdatavalid (out, 1) and avmm_response (out, 2; 00 OKAY, 10 SLVERR, 11 DECODEERROR).
REQ-012 SHALL have channel ports ch_address (out, NUM_CH*ADDR_WIDTH), ch_read (out, NUM_CH), ch_write (out, NUM_CH), ch_writedata (out, DATA_WIDTH, shared) and ch_byteenable (out, DATA_WIDTH/8, shared).
REQ-013 SHALL have channel ports ch_readdata (in, NUM_CH*DATA_WIDTH) and ch_readdatavalid (in, NUM_CH).
REQ-014 SHALL have status ports unmapped_cnt (out, 16), a count of unmapped accesses, and timeout_cnt (out, 16), a count of read timeouts.

Function
REQ-015 SHALL implement the FSM states IDLE, ISSUE, WAIT_RD and RESP, with avmm_waitrequest = (state != IDLE).
REQ-016 SHALL accept a command in IDLE when avmm_read|avmm_write (cycle T), registering address, writedata, byteenable, the decode result and the command type.
REQ-017 SHALL treat avmm_read and avmm_write asserted together as a read; the write is dropped.
REQ-018 SHALL decode as a hit on channel i when CH_BASE[i] <= addr <= CH_BASE[i]+CH_SPAN[i]-1, computed in ADDR_WIDTH+1 bits with no wrap; on overlap the lowest index wins.
REQ-019 SHALL, on a mapped access in ISSUE (T+1), drive a one-cycle pulse on ch_read[i] or ch_write[i] with ch_address[i] = addr - CH_BASE[i]; the pulse on every other channel is 0.
REQ-020 SHALL complete a mapped write at T+1: ISSUE goes to IDLE and waitrequest is low at T+2; writes carry no response.
REQ-021 SHALL take a mapped read from ISSUE to WAIT_RD, sampling ch_readdatavalid[i] in both ISSUE and WAIT_RD and ignoring valids from non-selected channels.
REQ-022 SHALL, when the selected valid is seen at cycle X, capture ch_readdata[i] and drive avmm_readdatavalid=1 and response 00 at X+1 (state RESP, one cycle), then return to IDLE.
REQ-023 SHALL use a timeout counter cleared in ISSUE and incremented each WAIT_RD cycle; reaching TIMEOUT_CYCLES without a valid gives RESP with ERR_RDATA, response 10 and timeout_cnt+1.
REQ-024 SHALL let a valid win when it coincides with the timeout terminal count.
REQ-025 SHALL, on an unmapped read, issue no channel pulse and drive avmm_readdatavalid at T+2 with ERR_RDATA and response 11.
REQ-026 SHALL drop an unmapped write, with waitrequest low at T+2.
REQ-027 SHALL increment unmapped_cnt for every unmapped access.
REQ-028 SHALL saturate both counters at 16'hFFFF.
REQ-029 SHALL hold avmm_readdatavalid at 0 outside RESP, with readdata/response don't-care there.

Reset
REQ-030 SHALL, while rst_n=0, immediately force state=IDLE and set waitrequest=0, readdatavalid=0, response=00, readdata=0, ch_read=0, ch_write=0, ch_address=0, both counters=0 and the timeout counter=0.
REQ-031 SHALL abandon a read pending at reset with no response, and ignore a late channel valid arriving after reset.

Verification
REQ-032 SHALL cover: write 'h821C data 'h12345678 with defaults -> ch_write[0] pulse at T+1, ch_address[0]='h4, waitrequest low at T+2.
REQ-033 SHALL cover: read 'h8240, ch_readdatavalid[1] two cycles after the pulse with 'hA5A5A5A5 -> avmm_readdatavalid one cycle later, readdata 'hA5A5A5A5, response 00.
REQ-034 SHALL cover: read 'h0100 -> no channel pulse, readdatavalid at T+2, readdata 'hDEADBEEF, response 11, unmapped_cnt=1.
REQ-035 SHALL cover: read 'h8218 with no channel valid -> response 10 after 64 WAIT_RD cycles, timeout_cnt=1; a valid on the terminal cycle instead returns OKAY.
REQ-036 SHALL cover: read 'h8238 while ch_readdatavalid[0] pulses -> that pulse is ignored and the host waits for ch_readdatavalid[1].
REQ-037 SHALL cover: rst_n low during WAIT_RD, then a channel valid after release -> no host readdatavalid, all outputs at reset values.
